serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 37 +++
 rtl/serial_adder_ctrl_full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for serial_adder_ctrl; the ovf wire exists only
// when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADD_OVF_EN
    , ovf
`endif
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder used as the serial datapath slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one result bit per clock, LSB first, through a single full adder.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// SHIFT | WIDTH edges, one sum bit produced per edge
// DONE  | single-cycle done pulse, then back to IDLE unconditionally
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  serial_adder_ctrl_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   s_sr_q, s_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          s_sr_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = {fa_sum, s_sr_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        // On the last bit carry_q is the carry into the MSB.
        if (cnt_q == LAST_CNT) begin
          sum_d   = {fa_sum, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8; checks ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   cycle_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t sb_q[$];

  serial_adder_ctrl_if #(.WIDTH(8)) ifc ();

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (ifc.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cycle_cnt);
      end else begin
        e = sb_q.pop_front();
        chk("done_cycle", cycle_cnt, e.due);
        chk("sum", {24'h0, ifc.sum}, {24'h0, e.sum});
        chk("cout", {31'h0, ifc.cout}, {31'h0, e.cout});
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", {31'h0, ifc.ovf}, {31'h0, e.ovf});
`endif
      end
    end
  end

  task automatic push_exp(input logic [7:0] s, input logic c, input logic o);
    exp_t e;
    e.sum  = s;
    e.cout = c;
    e.ovf  = o;
    e.due  = cycle_cnt + 8;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] s, input logic c, input logic o);
    @(negedge clk);
    ifc.a     = a;
    ifc.b     = b;
    ifc.cin   = ci;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(s, c, o);
    ifc.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ifc.busy !== 1'b0 || sb_q.size() != 0) && n < budget);
    chk("idle_within_budget", {31'h0, (ifc.busy !== 1'b0 || sb_q.size() != 0)}, 32'h0);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] s, input logic c, input logic o);
    issue(a, b, ci, s, c, o);
    wait_idle(30);
  endtask

  initial begin
    int busy_cycles;
    reset     = 1'b1;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    ifc.cin   = 1'b0;
    repeat (2) @(negedge clk);

    // start held during reset must be ignored, then taken on the first free edge
    ifc.start = 1'b1;
    ifc.a     = 8'h05;
    ifc.b     = 8'h03;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, ifc.busy}, 32'h0);
    chk("rst_done", {31'h0, ifc.done}, 32'h0);
    chk("rst_sum",  {24'h0, ifc.sum},  32'h0);
    chk("rst_cout", {31'h0, ifc.cout}, 32'h0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf",  {31'h0, ifc.ovf},  32'h0);
`endif
    reset = 1'b0;
    @(posedge clk);
    #1;
    push_exp(8'h08, 1'b0, 1'b0);
    ifc.start = 1'b0;
    busy_cycles = 0;
    repeat (20) begin
      @(negedge clk);
      if (ifc.busy === 1'b1) busy_cycles++;
    end
    chk("busy_cycles", busy_cycles, 9);
    wait_idle(30);

    run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run(8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0);

    // Operand churn and start pulses while busy: one result only, no partial sum
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 4) chk("sum_no_partial", {24'h0, ifc.sum}, 32'h11);
      ifc.start = 1'b1;
      ifc.a     = 8'(i * 37 + 1);
      ifc.b     = 8'(i * 91 + 5);
      ifc.cin   = i[0];
    end
    @(negedge clk);
    ifc.start = 1'b0;
    wait_idle(30);
    repeat (5) @(negedge clk);
    chk("sum_hold", {24'h0, ifc.sum}, 32'h30);

    // Reset sampled on the 4th SHIFT edge aborts without a done pulse
    @(negedge clk);
    ifc.a     = 8'h33;
    ifc.b     = 8'h44;
    ifc.cin   = 1'b0;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {31'h0, ifc.busy}, 32'h0);
    chk("abort_done", {31'h0, ifc.done}, 32'h0);
    chk("abort_sum",  {24'h0, ifc.sum},  32'h0);
    chk("abort_cout", {31'h0, ifc.cout}, 32'h0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle", {31'h0, ifc.busy}, 32'h0);
    run(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Continuous start: one accept every 10 cycles
    @(negedge clk);
    ifc.a     = 8'h01;
    ifc.b     = 8'h01;
    ifc.cin   = 1'b0;
    ifc.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (i % 10 == 0) push_exp(8'h02, 1'b0, 1'b0);
    end
    ifc.start = 1'b0;
    wait_idle(30);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
